// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared definitions for the dec_stage_vr decode stage:
//   - funct4 opcode constants and the vector-class bit
//   - bit positions of the fixed 16-bit instruction fields
//   - dec_bundle_t, the width-independent control part of the D/E payload
// -----------------------------------------------------------------------------
package dec_pkg;

    // Instruction layout: [15:12] funct4, [11:8] rd, [7:4] rs, [3:0] rt
    localparam int FIELD_W = 4;
    localparam int F4_LSB  = 12;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;
    localparam int VEC_BIT = F4_LSB + 3;   // funct4[3] marks the vector class

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;

    // Control half of the D/E register. The operand data is sized by the
    // top-level parameters and is therefore held alongside, not in here.
    typedef struct packed {
        logic               valid;
        logic [FIELD_W-1:0] funct4;
        logic               is_vec;
        logic [FIELD_W-1:0] rd;
    } dec_bundle_t;

    // A bubble is an all-zero bundle; OP_NOP is 0 so this is also the reset value.
    localparam dec_bundle_t DEC_BUBBLE = '{
        valid:  1'b0,
        funct4: OP_NOP,
        is_vec: 1'b0,
        rd:     '0
    };

    function automatic logic is_vec_op(input logic [FIELD_W-1:0] funct4);
        return funct4[3];
    endfunction

endpackage

// File: rtl/dec_regfile.sv
// -----------------------------------------------------------------------------
// dec_regfile
// 1-write / 2-read register file with write-through bypass and async reset.
// Parameters:
//   ADDR     address bits (2**ADDR entries)
//   DATA     entry width
//   ZERO_R0  1 = entry 0 reads as zero and ignores writes
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   we_i, wa_i, wd_i    write port
//   ra_a_i, ra_b_i      read addresses
//   rd_a_o, rd_b_o      read data (combinational, includes bypass)
// -----------------------------------------------------------------------------
module dec_regfile #(
    parameter int ADDR    = 4,
    parameter int DATA    = 16,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [ADDR-1:0] wa_i,
    input  logic [DATA-1:0] wd_i,
    input  logic [ADDR-1:0] ra_a_i,
    input  logic [ADDR-1:0] ra_b_i,
    output logic [DATA-1:0] rd_a_o,
    output logic [DATA-1:0] rd_b_o
);

    localparam int DEPTH = 2 ** ADDR;

    logic [DATA-1:0] r_mem [DEPTH];
    logic            w_we;

    // A write aimed at a hardwired-zero entry is dropped entirely, so it can
    // neither update storage nor be bypassed.
    assign w_we = we_i & ~(ZERO_R0 && (wa_i == '0));

    // NOTE: the whole array is cleared on reset because the pipeline relies on
    // every register reading 0 afterwards; this forces flops rather than RAM.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state is always assigned with <= so that all
                // flops sample the pre-edge values regardless of statement order.
                r_mem[i] <= '0;
            end
        end else if (w_we) begin
            r_mem[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = (ZERO_R0 && (ra_a_i == '0)) ? '0 :
                    (w_we && (wa_i == ra_a_i))  ? wd_i : r_mem[ra_a_i];
    assign rd_b_o = (ZERO_R0 && (ra_b_i == '0)) ? '0 :
                    (w_we && (wa_i == ra_b_i))  ? wd_i : r_mem[ra_b_i];

endmodule

// File: rtl/dec_stage_vr.sv
// -----------------------------------------------------------------------------
// dec_stage_vr
// Decode stage: scalar and vector register files with write-through bypass,
// load-use hazard detection and the D/E pipeline register (stall / flush).
// Ports:
//   clk_i, rst_i                  clock (rising edge), async active-high reset
//   valid_i, instr_i, next_pc_i   instruction from fetch
//   stall_i, flush_i              D/E hold / bubble-insert controls
//   we_s_i, wa_s_i, wd_s_i        scalar write-back port
//   we_v_i, wa_v_i, wd_v_i        vector write-back port
//   hazard_o                      load-use hazard, fetch must hold (comb.)
//   valid_o, next_pc_o, funct4_o,
//   is_vec_o, rd_o                registered decoded control
//   rs_o, rt_o, vs_o, vt_o        registered scalar / vector operands
// -----------------------------------------------------------------------------
module dec_stage_vr
    import dec_pkg::*;
#(
    parameter int INST_SIZE = 16,
    parameter int ADDR_SIZE = 16,
    parameter int RADDR     = 4,
    parameter int RDATA     = 16,
    parameter int VADDR     = 2,
    parameter int VDATA     = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [INST_SIZE-1:0] instr_i,
    input  logic [ADDR_SIZE-1:0] next_pc_i,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 we_s_i,
    input  logic [RADDR-1:0]     wa_s_i,
    input  logic [RDATA-1:0]     wd_s_i,
    input  logic                 we_v_i,
    input  logic [VADDR-1:0]     wa_v_i,
    input  logic [VDATA-1:0]     wd_v_i,
    output logic                 hazard_o,
    output logic                 valid_o,
    output logic [ADDR_SIZE-1:0] next_pc_o,
    output logic [3:0]           funct4_o,
    output logic                 is_vec_o,
    output logic [RADDR-1:0]     rd_o,
    output logic [RDATA-1:0]     rs_o,
    output logic [RDATA-1:0]     rt_o,
    output logic [VDATA-1:0]     vs_o,
    output logic [VDATA-1:0]     vt_o
);

    // ---------------------------------------------------------------- fields
    logic [FIELD_W-1:0] w_funct4;
    logic [FIELD_W-1:0] w_rd_field;
    logic [FIELD_W-1:0] w_rs_field;
    logic [FIELD_W-1:0] w_rt_field;
    logic [RADDR-1:0]   w_rs_sa;
    logic [RADDR-1:0]   w_rt_sa;
    logic [VADDR-1:0]   w_rs_va;
    logic [VADDR-1:0]   w_rt_va;

    assign w_funct4   = instr_i[F4_LSB +: FIELD_W];
    assign w_rd_field = instr_i[RD_LSB +: FIELD_W];
    assign w_rs_field = instr_i[RS_LSB +: FIELD_W];
    assign w_rt_field = instr_i[RT_LSB +: FIELD_W];
    assign w_rs_sa    = w_rs_field[RADDR-1:0];
    assign w_rt_sa    = w_rt_field[RADDR-1:0];
    assign w_rs_va    = w_rs_field[VADDR-1:0];
    assign w_rt_va    = w_rt_field[VADDR-1:0];

    // -------------------------------------------------------- register files
    logic [RDATA-1:0] w_rs_data;
    logic [RDATA-1:0] w_rt_data;
    logic [VDATA-1:0] w_vs_data;
    logic [VDATA-1:0] w_vt_data;

    dec_regfile #(
        .ADDR    (RADDR),
        .DATA    (RDATA),
        .ZERO_R0 (1'b1)
    ) u_sreg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (we_s_i),
        .wa_i   (wa_s_i),
        .wd_i   (wd_s_i),
        .ra_a_i (w_rs_sa),
        .ra_b_i (w_rt_sa),
        .rd_a_o (w_rs_data),
        .rd_b_o (w_rt_data)
    );

    dec_regfile #(
        .ADDR    (VADDR),
        .DATA    (VDATA),
        .ZERO_R0 (1'b0)
    ) u_vreg (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .we_i   (we_v_i),
        .wa_i   (wa_v_i),
        .wd_i   (wd_v_i),
        .ra_a_i (w_rs_va),
        .ra_b_i (w_rt_va),
        .rd_a_o (w_vs_data),
        .rd_b_o (w_vt_data)
    );

    // ------------------------------------------------------------ D/E state
    dec_bundle_t          r_ctrl;
    logic [ADDR_SIZE-1:0] r_next_pc;
    logic [RDATA-1:0]     r_rs;
    logic [RDATA-1:0]     r_rt;
    logic [VDATA-1:0]     r_vs;
    logic [VDATA-1:0]     r_vt;

    // ---------------------------------------------------------------- hazard
    // A load in E whose destination is read by the scalar instruction in D
    // cannot be satisfied by bypass (data arrives only at WB), so D must wait.
    logic [RADDR-1:0] w_rd_e;
    logic             w_hazard;

    assign w_rd_e   = r_ctrl.rd[RADDR-1:0];
    assign w_hazard = valid_i & r_ctrl.valid & (r_ctrl.funct4 == OP_LOAD)
                    & ~instr_i[VEC_BIT] & (w_rd_e != '0)
                    & ((w_rd_e == w_rs_sa) | (w_rd_e == w_rt_sa));

    // ------------------------------------------------------ update selection
    logic w_load;
    logic w_bubble;

    always_comb begin
        // NOTE: defaults come first so every path assigns every signal;
        // a missing assignment on any branch would infer a latch.
        w_load   = 1'b0;
        w_bubble = 1'b0;
        if (flush_i) begin
            w_bubble = 1'b1;
        end else if (stall_i) begin
            w_bubble = 1'b0;                  // hold everything
        end else if (w_hazard || !valid_i) begin
            w_bubble = 1'b1;
        end else begin
            w_load = 1'b1;
        end
    end

    // Write-back during a stall updates the files but not the held operands;
    // the execute stage forwards from WB on its own.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ctrl    <= DEC_BUBBLE;
            r_next_pc <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_vs      <= '0;
            r_vt      <= '0;
        end else if (w_bubble) begin
            r_ctrl    <= DEC_BUBBLE;
            r_next_pc <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_vs      <= '0;
            r_vt      <= '0;
        end else if (w_load) begin
            r_ctrl.valid  <= 1'b1;
            r_ctrl.funct4 <= w_funct4;
            r_ctrl.is_vec <= is_vec_op(w_funct4);
            r_ctrl.rd     <= w_rd_field;
            r_next_pc     <= next_pc_i;
            r_rs          <= w_rs_data;
            r_rt          <= w_rt_data;
            r_vs          <= w_vs_data;
            r_vt          <= w_vt_data;
        end
    end

    // --------------------------------------------------------------- outputs
    assign hazard_o  = w_hazard;
    assign valid_o   = r_ctrl.valid;
    assign next_pc_o = r_next_pc;
    assign funct4_o  = r_ctrl.funct4;
    assign is_vec_o  = r_ctrl.is_vec;
    assign rd_o      = w_rd_e;
    assign rs_o      = r_rs;
    assign rt_o      = r_rt;
    assign vs_o      = r_vs;
    assign vt_o      = r_vt;

endmodule

// File: tb/tb_dec_stage_vr.sv
// -----------------------------------------------------------------------------
// tb_dec_stage_vr
// Directed stimulus for dec_stage_vr. The driver pushes the hand-derived D/E
// contents expected after each edge into a queue; a monitor pops one entry
// per clock and compares it with the outputs. Combinational hazard_o and the
// asynchronous reset response are checked directly by the driver.
// -----------------------------------------------------------------------------
module tb_dec_stage_vr;

    localparam logic [63:0] V2 = 64'h0123_4567_89AB_CDEF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [15:0] instr_i;
    logic [15:0] next_pc_i;
    logic        stall_i;
    logic        flush_i;
    logic        we_s_i;
    logic [3:0]  wa_s_i;
    logic [15:0] wd_s_i;
    logic        we_v_i;
    logic [1:0]  wa_v_i;
    logic [63:0] wd_v_i;
    logic        hazard_o;
    logic        valid_o;
    logic [15:0] next_pc_o;
    logic [3:0]  funct4_o;
    logic        is_vec_o;
    logic [3:0]  rd_o;
    logic [15:0] rs_o;
    logic [15:0] rt_o;
    logic [63:0] vs_o;
    logic [63:0] vt_o;

    always #5 clk_i = ~clk_i;

    dec_stage_vr #(
        .INST_SIZE (16),
        .ADDR_SIZE (16),
        .RADDR     (4),
        .RDATA     (16),
        .VADDR     (2),
        .VDATA     (64)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .instr_i   (instr_i),
        .next_pc_i (next_pc_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .we_s_i    (we_s_i),
        .wa_s_i    (wa_s_i),
        .wd_s_i    (wd_s_i),
        .we_v_i    (we_v_i),
        .wa_v_i    (wa_v_i),
        .wd_v_i    (wd_v_i),
        .hazard_o  (hazard_o),
        .valid_o   (valid_o),
        .next_pc_o (next_pc_o),
        .funct4_o  (funct4_o),
        .is_vec_o  (is_vec_o),
        .rd_o      (rd_o),
        .rs_o      (rs_o),
        .rt_o      (rt_o),
        .vs_o      (vs_o),
        .vt_o      (vt_o)
    );

    typedef struct {
        int          tag;
        logic        valid;
        logic [3:0]  funct4;
        logic        is_vec;
        logic [3:0]  rd;
        logic [15:0] pc;
        logic [15:0] rs;
        logic [15:0] rt;
        logic [63:0] vs;
        logic [63:0] vt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_out(input int tag, input logic v, input logic [3:0] f4,
                              input logic [3:0] rd, input logic [15:0] pc,
                              input logic [15:0] rs, input logic [15:0] rt,
                              input logic [63:0] vs, input logic [63:0] vt);
        exp_t e;
        e.tag    = tag;
        e.valid  = v;
        e.funct4 = f4;
        e.is_vec = f4[3];
        e.rd     = rd;
        e.pc     = pc;
        e.rs     = rs;
        e.rt     = rt;
        e.vs     = vs;
        e.vt     = vt;
        sb_q.push_back(e);
    endtask

    task automatic expect_bubble(input int tag);
        expect_out(tag, 1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 16'h0, 64'h0, 64'h0);
    endtask

    // Sets the fetch inputs and returns all side controls to idle.
    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc);
        valid_i   = v;
        instr_i   = ins;
        next_pc_i = pc;
        stall_i   = 1'b0;
        flush_i   = 1'b0;
        we_s_i    = 1'b0;
        wa_s_i    = 4'h0;
        wd_s_i    = 16'h0;
        we_v_i    = 1'b0;
        wa_v_i    = 2'h0;
        wd_v_i    = 64'h0;
    endtask

    // Monitor: one expected D/E snapshot per clock edge while any are queued.
    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (!rst_i && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("t%0d valid_o", e.tag),   64'(valid_o),   64'(e.valid));
            check($sformatf("t%0d funct4_o", e.tag),  64'(funct4_o),  64'(e.funct4));
            check($sformatf("t%0d is_vec_o", e.tag),  64'(is_vec_o),  64'(e.is_vec));
            check($sformatf("t%0d rd_o", e.tag),      64'(rd_o),      64'(e.rd));
            check($sformatf("t%0d next_pc_o", e.tag), 64'(next_pc_o), 64'(e.pc));
            check($sformatf("t%0d rs_o", e.tag),      64'(rs_o),      64'(e.rs));
            check($sformatf("t%0d rt_o", e.tag),      64'(rt_o),      64'(e.rt));
            check($sformatf("t%0d vs_o", e.tag),      vs_o,           e.vs);
            check($sformatf("t%0d vt_o", e.tag),      vt_o,           e.vt);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 16'h0, 16'h0);
        repeat (2) @(negedge clk_i);
        #1;
        check("reset valid_o",  64'(valid_o),  64'h0);
        check("reset rs_o",     64'(rs_o),     64'h0);
        check("reset vs_o",     vs_o,          64'h0);
        check("reset hazard_o", 64'(hazard_o), 64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Every scalar register reads 0 after reset.
        for (int i = 1; i < 16; i++) begin
            @(negedge clk_i);
            drive(1'b1, {4'h1, 4'h0, 4'(i), 4'(i)}, 16'(i));
            expect_out(i, 1'b1, 4'h1, 4'h0, 16'(i), 16'h0, 16'h0, 64'h0, 64'h0);
        end

        // Scalar write with same-cycle bypass, then writes to r0 are dropped.
        @(negedge clk_i);
        drive(1'b1, 16'h1055, 16'h0020);
        we_s_i = 1'b1; wa_s_i = 4'd5; wd_s_i = 16'hBEEF;
        expect_out(20, 1'b1, 4'h1, 4'h0, 16'h0020, 16'hBEEF, 16'hBEEF, 64'h0, 64'h0);
        @(negedge clk_i);
        drive(1'b1, 16'h1000, 16'h0021);
        we_s_i = 1'b1; wa_s_i = 4'd0; wd_s_i = 16'h1234;
        expect_out(21, 1'b1, 4'h1, 4'h0, 16'h0021, 16'h0, 16'h0, 64'h0, 64'h0);
        @(negedge clk_i);
        drive(1'b1, 16'h1005, 16'h0022);
        expect_out(22, 1'b1, 4'h1, 4'h0, 16'h0022, 16'h0, 16'hBEEF, 64'h0, 64'h0);

        // Vector path: write v2 under an invalid slot, then read it.
        @(negedge clk_i);
        drive(1'b0, 16'h1000, 16'h0);
        we_v_i = 1'b1; wa_v_i = 2'd2; wd_v_i = V2;
        expect_bubble(30);
        @(negedge clk_i);
        drive(1'b1, 16'h8021, 16'h0031);
        expect_out(31, 1'b1, 4'h8, 4'h0, 16'h0031, 16'h0, 16'h0, V2, 64'h0);

        // Load-use on rs: bubble, then the held instruction issues with WB bypass.
        @(negedge clk_i);
        drive(1'b1, 16'h2300, 16'h0040);
        #1 check("hazard after vector op", 64'(hazard_o), 64'h0);
        expect_out(40, 1'b1, 4'h2, 4'h3, 16'h0040, 16'h0, 16'h0, 64'h0, 64'h0);
        @(negedge clk_i);
        drive(1'b1, 16'h1430, 16'h0041);
        #1 check("hazard load-use rs", 64'(hazard_o), 64'h1);
        expect_bubble(41);
        @(negedge clk_i);
        drive(1'b1, 16'h1430, 16'h0041);
        we_s_i = 1'b1; wa_s_i = 4'd3; wd_s_i = 16'hCAFE;
        #1 check("hazard after bubble", 64'(hazard_o), 64'h0);
        expect_out(42, 1'b1, 4'h1, 4'h4, 16'h0041, 16'hCAFE, 16'h0, 64'h0, 64'h0);

        // Vector consumer of a load is never a hazard.
        @(negedge clk_i);
        drive(1'b1, 16'h2300, 16'h0043);
        expect_out(43, 1'b1, 4'h2, 4'h3, 16'h0043, 16'h0, 16'h0, 64'h0, 64'h0);
        @(negedge clk_i);
        drive(1'b1, 16'h8030, 16'h0044);
        #1 check("hazard vector consumer", 64'(hazard_o), 64'h0);
        expect_out(44, 1'b1, 4'h8, 4'h0, 16'h0044, 16'hCAFE, 16'h0, 64'h0, 64'h0);

        // Load-use on rt.
        @(negedge clk_i);
        drive(1'b1, 16'h2300, 16'h0045);
        expect_out(45, 1'b1, 4'h2, 4'h3, 16'h0045, 16'h0, 16'h0, 64'h0, 64'h0);
        @(negedge clk_i);
        drive(1'b1, 16'h1503, 16'h0046);
        #1 check("hazard load-use rt", 64'(hazard_o), 64'h1);
        expect_bubble(46);

        // Stall holds for 3 cycles despite new input and WB; flush beats stall.
        @(negedge clk_i);
        drive(1'b1, 16'h1763, 16'h0050);
        expect_out(50, 1'b1, 4'h1, 4'h7, 16'h0050, 16'h0, 16'hCAFE, V2, 64'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            drive(1'b1, 16'h1111, 16'h0099);
            stall_i = 1'b1;
            we_s_i = 1'b1; wa_s_i = 4'd3; wd_s_i = 16'h0BAD;
            expect_out(51 + k, 1'b1, 4'h1, 4'h7, 16'h0050, 16'h0, 16'hCAFE, V2, 64'h0);
        end
        @(negedge clk_i);
        drive(1'b1, 16'h1111, 16'h0099);
        stall_i = 1'b1; flush_i = 1'b1;
        expect_bubble(54);
        @(negedge clk_i);
        drive(1'b1, 16'h1030, 16'h0060);
        expect_out(60, 1'b1, 4'h1, 4'h0, 16'h0060, 16'h0BAD, 16'h0, 64'h0, 64'h0);

        // Reset mid-cycle: outputs clear at once, register contents are lost.
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        check("midrst valid_o",   64'(valid_o),   64'h0);
        check("midrst next_pc_o", 64'(next_pc_o), 64'h0);
        check("midrst funct4_o",  64'(funct4_o),  64'h0);
        check("midrst rs_o",      64'(rs_o),      64'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        drive(1'b1, 16'h1023, 16'h0070);
        expect_out(70, 1'b1, 4'h1, 4'h0, 16'h0070, 16'h0, 16'h0, 64'h0, 64'h0);
        @(negedge clk_i);
        drive(1'b0, 16'h0, 16'h0);
        expect_bubble(71);

        repeat (3) @(negedge clk_i);
        check("scoreboard drained", 64'(sb_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
